// File: rtl/program_counter_pkg.sv
// Shared types for the fetch PC / branch unit: branch conditions, next-PC
// select encoding and the flag-based condition evaluator.
package program_counter_pkg;

   typedef enum logic [2:0] {
      ZERO, NOT_ZERO, POSITIVE, NEGATIVE,
      CARRY_SET, CARRY_CLEARED, OVERFLOW_SET, OVERFLOW_CLEARED
   } branch_condition_e;

   typedef enum logic [2:0] {HOLD, RET, CALL, BRANCH, SEQ} pc_sel_e;

   function automatic logic cond_eval(input branch_condition_e cond,
                                      input logic z, input logic n,
                                      input logic c, input logic v);
      logic r;
      r = 1'b0;
      case (cond)
         ZERO:             r = z;
         NOT_ZERO:         r = !z;
         POSITIVE:         r = !z && !n;
         NEGATIVE:         r = n;
         CARRY_SET:        r = c;
         CARRY_CLEARED:    r = !c;
         OVERFLOW_SET:     r = v;
         OVERFLOW_CLEARED: r = !v;
         default:          r = 1'b0;
      endcase
      return r;
   endfunction

endpackage

// File: rtl/return_address_stack.sv
// Circular return-address stack; a push when full overwrites the oldest entry.
// Only instantiated when PC_RAS_EN is defined.
module return_address_stack #(
   parameter int PC_WIDTH  = 16,
   parameter int RAS_DEPTH = 4
) (
   input  logic                             clk,
   input  logic                             rst,
   input  logic                             push,
   input  logic                             pop,
   input  logic [PC_WIDTH-1:0]              push_data,
   output logic [PC_WIDTH-1:0]              pop_data,
   output logic                             full,
   output logic                             empty,
   output logic [$clog2(RAS_DEPTH+1)-1:0]   count
);

   localparam int PW = $clog2(RAS_DEPTH);
   localparam int CW = $clog2(RAS_DEPTH + 1);

   logic [PW-1:0]       top_q, top_d;
   logic [CW-1:0]       count_q, count_d;
   logic [PC_WIDTH-1:0] mem_q [RAS_DEPTH];

   assign full     = (count_q == CW'(RAS_DEPTH));
   assign empty    = (count_q == '0);
   assign count    = count_q;
   assign pop_data = mem_q[top_q];

   always_comb begin
      top_d   = top_q;
      count_d = count_q;
      if (push) begin
         // Pointer always advances; when full the slot reached is the oldest.
         top_d = top_q + 1'b1;
         if (!full) count_d = count_q + 1'b1;
      end else if (pop && !empty) begin
         top_d   = top_q - 1'b1;
         count_d = count_q - 1'b1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         top_q   <= '0;
         count_q <= '0;
      end else begin
         top_q   <= top_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) mem_q[top_d] <= push_data;
   end

endmodule

// File: rtl/pc_branch_unit.sv
// Fetch program counter with conditional/relative branches and call/return.
// Define PC_RAS_EN to build the return-address stack; otherwise ret underflows.
module pc_branch_unit
   import program_counter_pkg::*;
#(
   parameter int                     PC_WIDTH     = 16,
   parameter int                     RAS_DEPTH    = 4,
   parameter logic [PC_WIDTH-1:0]    RESET_VECTOR = '0
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                stall,
   input  logic                branch_valid,
   input  branch_condition_e   branch_cond,
   input  logic                branch_relative,
   input  logic [PC_WIDTH-1:0] branch_target,
   input  logic                call,
   input  logic                ret,
   input  logic                flag_zero,
   input  logic                flag_negative,
   input  logic                flag_carry,
   input  logic                flag_overflow,
   output logic [PC_WIDTH-1:0] pc,
   output logic                redirect,
   output logic                ras_overflow,
   output logic                ras_underflow,
   output logic                illegal_req
);

   if (PC_WIDTH < 4 || RAS_DEPTH < 2 || (RAS_DEPTH & (RAS_DEPTH - 1)) != 0) begin : g_bad_param
      $error("pc_branch_unit: illegal PC_WIDTH/RAS_DEPTH");
   end

   logic [PC_WIDTH-1:0] pc_q, pc_d, pc_plus1, target;
   logic                redirect_q, redirect_d;
   logic                ovf_q, ovf_d, unf_q, unf_d, illegal_q, illegal_d;
   logic                multi_req;
   pc_sel_e             sel;
   logic                ras_full, ras_empty, ras_pop_ok;
   logic [PC_WIDTH-1:0] ras_top;

   assign pc_plus1  = pc_q + 1'b1;
   assign target    = branch_relative ? pc_q + branch_target : branch_target;
   assign multi_req = (ret && call) || (ret && branch_valid) || (call && branch_valid);

   always_comb begin
      if (stall)                                                          sel = HOLD;
      else if (ret)                                                       sel = RET;
      else if (call)                                                      sel = CALL;
      else if (branch_valid &&
               cond_eval(branch_cond, flag_zero, flag_negative, flag_carry, flag_overflow))
                                                                          sel = BRANCH;
      else                                                                sel = SEQ;
   end

`ifdef PC_RAS_EN
   logic [$clog2(RAS_DEPTH+1)-1:0] ras_count;

   assign ras_pop_ok = (ras_count != '0);

   return_address_stack #(.PC_WIDTH(PC_WIDTH), .RAS_DEPTH(RAS_DEPTH)) u_ras (
      .clk       (clk),
      .rst       (reset),
      .push      (sel == CALL),
      .pop       ((sel == RET) && ras_pop_ok),
      .push_data (pc_plus1),
      .pop_data  (ras_top),
      .full      (ras_full),
      .empty     (ras_empty),
      .count     (ras_count)
   );
`else
   assign ras_pop_ok = 1'b0;
   assign ras_full   = 1'b0;
   assign ras_empty  = 1'b1;
   assign ras_top    = '0;
`endif

   always_comb begin
      pc_d       = pc_q;
      redirect_d = redirect_q;
      ovf_d      = ovf_q;
      unf_d      = unf_q;
      illegal_d  = !stall && multi_req;
      case (sel)
         RET: begin
            if (ras_empty || !ras_pop_ok) begin
               pc_d       = pc_plus1;
               redirect_d = 1'b0;
               unf_d      = 1'b1;
            end else begin
               pc_d       = ras_top;
               redirect_d = 1'b1;
            end
         end
         CALL: begin
            pc_d       = target;
            redirect_d = 1'b1;
            ovf_d      = ovf_q || ras_full;
         end
         BRANCH: begin
            pc_d       = target;
            redirect_d = 1'b1;
         end
         SEQ: begin
            pc_d       = pc_plus1;
            redirect_d = 1'b0;
         end
         default: ;
      endcase
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         pc_q       <= RESET_VECTOR;
         redirect_q <= 1'b0;
         ovf_q      <= 1'b0;
         unf_q      <= 1'b0;
         illegal_q  <= 1'b0;
      end else begin
         pc_q       <= pc_d;
         redirect_q <= redirect_d;
         ovf_q      <= ovf_d;
         unf_q      <= unf_d;
         illegal_q  <= illegal_d;
      end
   end

   assign pc            = pc_q;
   assign redirect      = redirect_q;
   assign ras_overflow  = ovf_q;
   assign ras_underflow = unf_q;
   assign illegal_req   = illegal_q;

endmodule

// File: doc/pc_branch_unit.md
# pc_branch_unit

Parametrised program counter for the CPU front end. It holds the fetch address and advances it each cycle. It evaluates the eight `branch_condition_e` conditions against ALU flags to redirect fetch, absolutely or PC-relative. It also supports call/return through a small circular return-address stack (RAS). It sits between the decoder/ALU flag register and the instruction-memory address port.

## Interface
Parameters:
- `PC_WIDTH`, 16: width of the PC, targets and RAS entries; minimum 4.
- `RAS_DEPTH`, 4: number of return-address stack entries; power of two, at least 2.
- `RESET_VECTOR`, 0: PC value loaded on reset, `PC_WIDTH` bits.

Ports:
- `clk`: input, 1. Single clock; all state updates on the rising edge.
- `reset`: input, 1. Asynchronous, active-high.
- `stall`: input, 1. Freezes all state.
- `branch_valid`: input, 1. Conditional branch request this cycle.
- `branch_cond`: input, `branch_condition_e`. Condition to evaluate.
- `branch_relative`: input, 1. 1 selects PC-relative, 0 selects absolute.
- `branch_target`: input, `PC_WIDTH`. Absolute target, or two's-complement offset.
- `call`: input, 1. Unconditional jump to `branch_target` (same relative rule) and push PC+1.
- `ret`: input, 1. Pop the RAS into the PC.
- `flag_zero`, `flag_negative`, `flag_carry`, `flag_overflow`: input, 1 each. Current ALU flags.
- `pc`: output, `PC_WIDTH`. Current fetch address, registered.
- `redirect`: output, 1. Registered; high in the cycle `pc` holds a non-sequential value.
- `ras_overflow`: output, 1. Sticky; a push overwrote a live entry.
- `ras_underflow`: output, 1. Sticky; a pop was attempted on an empty stack.
- `illegal_req`: output, 1. Registered one-cycle pulse: more than one of `branch_valid`/`call`/`ret` was high.

## Operation
- Condition evaluation:
  - ZERO: Z.
  - NOT_ZERO: !Z.
  - POSITIVE: !Z && !N.
  - NEGATIVE: N.
  - CARRY_SET: C.
  - CARRY_CLEARED: !C.
  - OVERFLOW_SET: V.
  - OVERFLOW_CLEARED: !V.
- Effective target is `branch_target` when absolute, or `pc + branch_target` when relative. The sum is truncated modulo 2^`PC_WIDTH`, so it wraps silently.
- Next-PC priority:
  1. `stall`: hold everything. Flag inputs and requests are ignored, and `illegal_req` is not raised.
  2. `ret`: pop. If the stack is empty, go to `pc+1` and set `ras_underflow`.
  3. `call`: push `pc+1` and jump to the target.
  4. `branch_valid` with the condition true: jump to the target.
  5. Otherwise: `pc+1`, wrapping from all-ones to 0.
- Multiple requests: when more than one of `ret`/`call`/`branch_valid` is high, the highest priority wins and `illegal_req` pulses the next cycle.
- A branch whose condition is false gives `pc+1` and `redirect`=0.
- RAS structure: a circular buffer with a top pointer and an occupancy count (0..`RAS_DEPTH`).
- Push when full: overwrite the oldest entry, keep count at `RAS_DEPTH`, set `ras_overflow`.
- Pop: return the most recent entry and decrement count.
- Sticky flags clear only on `reset`.

## Timing
- Reset, asynchronous: `pc`=`RESET_VECTOR`, `redirect`=0, `ras_overflow`=0, `ras_underflow`=0, `illegal_req`=0, RAS count=0. RAS entry contents are don't-care.
- Reset deasserted mid-call is safe: the RAS empties, and a following `ret` underflows.
- Latency is one cycle. A request sampled at edge N makes `pc` take the target value after edge N; `redirect` is high for that same cycle only.
- No handshake: requests are single-cycle strobes, qualified by `!stall`. A strobe held for k unstalled cycles acts k times.
- Flags are sampled in the same cycle as `branch_valid`; there is no internal forwarding.
- `stall` takes effect on the edge it is sampled; `pc` and `redirect` hold their values.

## Configuration
- `PC_RAS_EN` defined: RAS, `call` push and `ret` pop are present as described.
- `PC_RAS_EN` undefined: no RAS storage.
  - `call` behaves as an unconditional jump with no push.
  - `ret` is treated as `pc+1` and sets `ras_underflow`.
  - `ras_overflow` is tied to 0.
  - `RAS_DEPTH` is ignored.

## Structure
- `program_counter_pkg` keeps `branch_condition_e`.
- Add to `program_counter_pkg`:
  - `pc_sel_e` (HOLD, RET, CALL, BRANCH, SEQ).
  - A `cond_eval` function taking a condition and four flags and returning 1 bit.
- One sub-module, `return_address_stack`: push/pop/full/empty/count, `PC_WIDTH` × `RAS_DEPTH`, same clock and reset. It lives under `PC_RAS_EN` only.

## Test plan
- Reset and increment: reset with `RESET_VECTOR`=0x0100, then release for 3 cycles → `pc`=0x0100, 0x0101, 0x0102, 0x0103; `redirect`=0 throughout.
- Conditions: for each of the 8 conditions with flag combinations, taken or not taken against absolute target 0x2000 → `pc`=0x2000 with `redirect`=1 only when the condition is true.
  - POSITIVE with Z=0, N=0 is taken.
  - POSITIVE with Z=1, N=0 is not taken.
- Relative wrap: `pc`=0xFFFE, relative offset 0x0004, ZERO with Z=1 → `pc`=0x0002.
- Relative backward: `pc`=0x0010, offset 0xFFF0 → `pc`=0x0000.
- RAS (`RAS_DEPTH`=4):
  - Calls at 0x10, 0x20, 0x30, 0x40, 0x50 → `ras_overflow`=1.
  - Then 4 rets → `pc`=0x51, 0x41, 0x31, 0x21.
  - A 5th ret → `pc`=0x22 and `ras_underflow`=1.
- Stall and collisions:
  - `stall`=1 with `call` high → `pc` unchanged and no push.
  - `call` and `ret` together (unstalled) → the ret wins and `illegal_req` pulses for 1 cycle.
- Reset mid-stream: assert `reset` asynchronously between edges after 2 calls → `pc`=`RESET_VECTOR` immediately, with the sticky flags and RAS cleared.
